// File: rtl/fir_pkg.sv
// Shared helpers and types for the multi-channel time-shared FIR filter.
package fir_pkg;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result++;
      rest = rest >> 1;
    end
    return result;
  endfunction

  // Width of a tap index; never narrower than one bit.
  function automatic int tap_width(input int taps);
    return (clog2(taps) < 1) ? 1 : clog2(taps);
  endfunction

  // Full-precision result width: product width plus growth for N additions.
  function automatic int output_width(input int iw, input int cw, input int taps);
    return iw + cw + clog2(taps);
  endfunction

  // Derived widths for the default configuration (3 taps, 8-bit samples and coefficients).
  localparam int TAP_WIDTH    = tap_width(3);
  localparam int OUTPUT_WIDTH = output_width(8, 8, 3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// sum is the value the accumulator takes on the next enabled edge.
module fir_mac #(
  parameter int INPUT_WIDTH  = 8,
  parameter int COEF_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 18
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           en,
  input  logic signed [INPUT_WIDTH-1:0]  sample,
  input  logic signed [COEF_WIDTH-1:0]   coef,
  output logic signed [OUTPUT_WIDTH-1:0] acc,
  output logic signed [OUTPUT_WIDTH-1:0] sum
);

  localparam int PROD_WIDTH = INPUT_WIDTH + COEF_WIDTH;

  logic signed [PROD_WIDTH-1:0] product;

  // Full-precision signed product, sign-extended into the accumulator width.
  always_comb begin
    product = PROD_WIDTH'(sample) * PROD_WIDTH'(coef);
    sum     = acc + OUTPUT_WIDTH'(product);
  end

  // Accumulator register: clear has priority over accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fir_filter_mc.sv
// Multi-channel, coefficient-programmable FIR filter sharing one MAC.
// Each accepted sample shifts its channel's delay line, then NUM_OF_TAPS
// MAC cycles run and the result is presented with a one-cycle strobe.
//
// Input handshake: input_data_flag is a single-cycle valid with no ready
// signal. A sample is taken only when busy is low and input_channel is a
// real channel; any other valid cycle is discarded and sets sticky dropped.
// Coefficient writes follow the same rule (idle and in-range address) and
// a discarded write sets sticky coef_err.
module fir_filter_mc
  import fir_pkg::*;
#(
  parameter int  NUM_OF_TAPS  = 3,
  parameter int  INPUT_WIDTH  = 8,
  parameter int  COEF_WIDTH   = 8,
  parameter int  NUM_CHANNELS = 2,
  parameter int  CH_WIDTH     = 1,
  localparam int TAP_W        = tap_width(NUM_OF_TAPS),
  localparam int OUT_W        = output_width(INPUT_WIDTH, COEF_WIDTH, NUM_OF_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [INPUT_WIDTH-1:0] input_data,
  input  logic                          input_data_flag,
  input  logic [CH_WIDTH-1:0]           input_channel,
  input  logic                          coef_wr_en,
  input  logic [TAP_W-1:0]              coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0]  coef_wr_data,
  output logic signed [OUT_W-1:0]       output_data,
  output logic                          output_data_flag,
  output logic [CH_WIDTH-1:0]           output_channel,
  output logic                          busy,
  output logic                          dropped,
  output logic                          coef_err
);

  localparam logic [CH_WIDTH:0] NUM_CH_LIMIT = (CH_WIDTH + 1)'(NUM_CHANNELS);
  localparam logic [TAP_W:0]    NUM_TAP_LIMIT = (TAP_W + 1)'(NUM_OF_TAPS);
  localparam logic [TAP_W-1:0]  LAST_TAP      = TAP_W'(NUM_OF_TAPS - 1);

  state_t                        state;
  logic [CH_WIDTH-1:0]           ch;
  logic [TAP_W-1:0]              tap;
  logic signed [INPUT_WIDTH-1:0] x_line [NUM_CHANNELS][NUM_OF_TAPS];
  logic signed [COEF_WIDTH-1:0]  coef   [NUM_OF_TAPS];

  logic                          ch_ok;
  logic                          addr_ok;
  logic                          accept;
  logic                          coef_ok;
  logic signed [INPUT_WIDTH-1:0] mac_sample;
  logic signed [COEF_WIDTH-1:0]  mac_coef;
  logic signed [OUT_W-1:0]       mac_acc;
  logic signed [OUT_W-1:0]       mac_sum;

  // Acceptance decisions and the operand mux feeding the shared MAC.
  always_comb begin
    ch_ok      = {1'b0, input_channel} < NUM_CH_LIMIT;
    addr_ok    = {1'b0, coef_wr_addr} < NUM_TAP_LIMIT;
    accept     = input_data_flag && (state == IDLE) && ch_ok;
    coef_ok    = coef_wr_en && (state == IDLE) && addr_ok;
    mac_sample = x_line[ch][tap];
    mac_coef   = coef[tap];
  end

  fir_mac #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .COEF_WIDTH   (COEF_WIDTH),
    .OUTPUT_WIDTH (OUT_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .en     (state == MAC),
    .sample (mac_sample),
    .coef   (mac_coef),
    .acc    (mac_acc),
    .sum    (mac_sum)
  );

  // Control FSM with registered outputs; the last MAC edge loads the result
  // directly from the accumulator's next value so the strobe lands in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      ch               <= '0;
      tap              <= '0;
      output_data      <= '0;
      output_data_flag <= 1'b0;
      output_channel   <= '0;
      busy             <= 1'b0;
      dropped          <= 1'b0;
    end else begin
      output_data_flag <= 1'b0;
      if (input_data_flag && !accept) begin
        dropped <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            ch    <= input_channel;
            tap   <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          tap <= tap + 1'b1;
          if (tap == LAST_TAP) begin
            output_data      <= mac_sum;
            output_channel   <= ch;
            output_data_flag <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-channel delay lines: only the addressed channel shifts on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int k = 0; k < NUM_OF_TAPS; k++) begin
          x_line[c][k] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (accept && (CH_WIDTH'(c) == input_channel)) begin
          x_line[c][0] <= input_data;
          for (int k = 1; k < NUM_OF_TAPS; k++) begin
            x_line[c][k] <= x_line[c][k-1];
          end
        end
      end
    end
  end

  // Coefficient register file, reset to identity, plus the write-error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        coef[k] <= (k == 0) ? COEF_WIDTH'(1) : '0;
      end
      coef_err <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        if (coef_ok && (TAP_W'(k) == coef_wr_addr)) begin
          coef[k] <= coef_wr_data;
        end
      end
      if (coef_wr_en && !coef_ok) begin
        coef_err <= 1'b1;
      end
    end
  end

endmodule
